serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/fa_slice.sv | 23 ++
 rtl/serial_adder.sv | 162 ++++++++++++++++
 tb/tb_serial_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Supported operand width range
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/fa_slice.sv
// Combinational full-adder slice built from two half adders and an OR.
module fa_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder on the operand bits, second folds in the carry
    always_comb begin
        ha0_s = a_i ^ b_i;
        ha0_c = a_i & b_i;
        s_o   = ha0_s ^ c_i;
        ha1_c = ha0_s & c_i;
        c_o   = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice iterated LSB-first over WIDTH bits,
// with a start/busy/done handshake. Result is held until the next operation.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of supported range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             carry_msb_q, carry_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_co;
    logic last_bit;
    // The LSB of the sum shift register is shifted out and never consumed
    logic unused_s_lsb;

    assign unused_s_lsb = s_sr_q[0];

    fa_slice u_fa_slice (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        carry_msb_d = carry_msb_q;
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    s_sr_d  = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    carry_msb_d = 1'b0;
`endif
                end
            end
            ADD: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                // Carry out of bit WIDTH-2 is the carry entering the MSB
                if (cnt_q == CntW'(WIDTH - 2)) begin
                    carry_msb_d = fa_co;
                end
`endif
                if (last_bit) begin
                    sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_msb_q ^ fa_co;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            carry_msb_q <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            carry_msb_q <= carry_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Moore outputs decoded from registered state
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8); ovf checks when SERIAL_ADDER_OVF_EN is set.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Expected {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] r;
        logic       v;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {v, r};
    endfunction

    // Pop the oldest expectation and compare it with the current outputs
    task automatic check_result(input string name);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: result with empty scoreboard sum=%h", name, sum);
            return;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({cout, sum} !== e[W:0]) begin
            n_err++;
            $display("FAIL %s: {cout,sum} got %h expected %h", name, {cout, sum}, e[W:0]);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_cmp++;
        if (ovf !== e[W+1]) begin
            n_err++;
            $display("FAIL %s: ovf got %b expected %b", name, ovf, e[W+1]);
        end
`endif
    endtask

    // One complete operation from idle, checking latency, result and pulse width
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input string name);
        int lat;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; cin = tc;
        exp_q.push_back(model(ta, tb_, tc));
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: no done after %0d cycles, required %0d", name, lat, W + 1);
            void'(exp_q.pop_front());
            return;
        end
        if (lat != W + 1) begin
            n_err++;
            $display("FAIL %s_latency: done after %0d cycles, required %0d", name, lat, W + 1);
        end
        check_result(name);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_pulse: done=%b busy=%b after done, required 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, sum, cout} !== '0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, required all 0",
                     busy, done, sum, cout);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
        end
`endif
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b after reset, required 0", busy);
        end
    endtask

    task automatic test_basic();
        run_op(8'h0F, 8'h01, 1'b0, "add_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(8'h00, 8'h00, 1'b1, "add_cin");
        run_op(8'h7F, 8'h01, 1'b0, "ovf_pos");
        run_op(8'h80, 8'h80, 1'b0, "ovf_neg");
    endtask

    task automatic test_ignore_start();
        int dcnt = 0;
        int late_busy = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b0;
        exp_q.push_back(model(8'h05, 8'h03, 1'b0));
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            if (k >= 10 && busy) late_busy++;
            if (done) begin
                dcnt++;
                if (dcnt == 1) check_result("ignore_start");
                start = 1'b1; a = 8'h11; b = 8'h22;
            end else if (k == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (dcnt != 1) begin
            n_err++;
            $display("FAIL ignore_done_count: %0d done pulses, required 1", dcnt);
        end
        n_cmp++;
        if (late_busy != 0) begin
            n_err++;
            $display("FAIL ignore_busy: busy in %0d cycles after done, required 0", late_busy);
        end
        n_cmp++;
        if (sum !== 8'h08) begin
            n_err++;
            $display("FAIL ignore_hold: sum=%h, required 08", sum);
        end
    endtask

    task automatic test_reset_mid();
        int dcnt = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Now in the first ADD cycle; move to the fourth
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, sum, cout} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, required all 0",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        n_cmp++;
        if (dcnt != 0) begin
            n_err++;
            $display("FAIL reset_mid_done: %0d done pulses after abort, required 0", dcnt);
        end
        run_op(8'hAA, 8'h55, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int last = -1;
        for (int i = 0; i <= 2000; i++) begin
            if (done) begin
                ndone++;
                check_result("b2b");
                if (last >= 0) begin
                    n_cmp++;
                    if (i - last != W + 2) begin
                        n_err++;
                        $display("FAIL b2b_spacing: done spacing %0d, required %0d",
                                 i - last, W + 2);
                    end
                end
                last = i;
            end
            if (i < 2000) begin
                start = 1'b1;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                // Accept edges follow every (W+2)th drive while start is held
                if (i % (W + 2) == 0) exp_q.push_back(model(a, b, cin));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ndone != 200 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: %0d done pulses, %0d pending, required 200 and 0",
                     ndone, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
